// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin-machine training blocks: feedback encodings,
// update FSM states and the literal-ordering helpers.
package tm_pkg;

  localparam logic [1:0] FB_NONE  = 2'b00;
  localparam logic [1:0] FB_TYPE1 = 2'b01;
  localparam logic [1:0] FB_TYPE2 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } tm_state_e;

  // Literals are ordered {features, ~features}: the low half are the negations.
  function automatic logic lit_is_neg(input int idx, input int nf);
    return idx < nf;
  endfunction

  function automatic int lit_feat_idx(input int idx, input int nf);
    return (idx < nf) ? idx : idx - nf;
  endfunction

endpackage

// File: rtl/tm_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11), advances once per cycle while en_i is high.
module tm_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ta_feedback_update.sv
// TA team of one clause: evaluates the clause at accept, applies Type I/II feedback one literal
// per cycle and republishes the exclude mask. Define TM_LFSR_EN to use the internal LFSR as random source.
module ta_feedback_update
  import tm_pkg::*;
#(
  parameter int          NUM_FEATURES = 2,
  parameter int          N_STATES     = 100,
  parameter int          RAND_W       = 8,
  parameter int          P_LOW        = 26,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fb_valid,
  output logic                      fb_ready,
  input  logic [1:0]                fb_type,
  input  logic [NUM_FEATURES-1:0]   features,
  input  logic [RAND_W-1:0]         rand_in,
  output logic [2*NUM_FEATURES-1:0] exclude_state,
  output logic                      clause_out,
  output logic                      done
);

  localparam int NL    = 2 * NUM_FEATURES;
  localparam int CNT_W = $clog2(2 * N_STATES + 1);
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;

  localparam logic [CNT_W-1:0]  CNT_MIN  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'(N_STATES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(2 * N_STATES);
  localparam logic [RAND_W-1:0] P_LOW_R  = RAND_W'(P_LOW);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NL - 1);

  tm_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [NUM_FEATURES-1:0]  feat_q, feat_d;
  logic [1:0]               type_q, type_d;
  logic                     clause_q, clause_d;
  logic [NL-1:0]            mask_q, mask_d;
  logic [CNT_W-1:0]         cnt_q [NL];
  logic [CNT_W-1:0]         cnt_d [NL];

  logic [NL-1:0]            lits, lits_in, excl_now, excl_next;
  logic [RAND_W-1:0]        r;
  logic                     r_low, accept, is_fb;

`ifdef TM_LFSR_EN
  logic [15:0] lfsr_val;
  logic        unused_rand;

  tm_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q == ST_UPDATE),
    .lfsr_o (lfsr_val)
  );

  assign r           = lfsr_val[RAND_W-1:0];
  assign unused_rand = ^rand_in;
`else
  assign r = rand_in;
`endif

  assign r_low  = r < P_LOW_R;
  assign accept = fb_valid && (state_q == ST_IDLE);
  assign is_fb  = (fb_type == FB_TYPE1) || (fb_type == FB_TYPE2);

  for (genvar gi = 0; gi < NL; gi++) begin : g_lit
    localparam int FI = lit_feat_idx(gi, NUM_FEATURES);
    if (lit_is_neg(gi, NUM_FEATURES)) begin : g_neg
      assign lits[gi]    = ~feat_q[FI];
      assign lits_in[gi] = ~features[FI];
    end else begin : g_pos
      assign lits[gi]    = feat_q[FI];
      assign lits_in[gi] = features[FI];
    end
    assign excl_now[gi]  = cnt_q[gi] <= CNT_MID;
    assign excl_next[gi] = cnt_d[gi] <= CNT_MID;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (fb_valid) state_d = is_fb ? ST_UPDATE : ST_DONE;
      ST_UPDATE: if (idx_q == IDX_LAST) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    fb_ready = (state_q == ST_IDLE);
    done     = (state_q == ST_DONE);
  end

  always_comb begin
    idx_d    = (state_q == ST_UPDATE) ? idx_q + IDX_W'(1) : '0;
    feat_d   = accept ? features : feat_q;
    type_d   = accept ? fb_type  : type_q;
    clause_d = accept ? &(mask_q | lits_in) : clause_q;
    mask_d   = (state_d == ST_DONE) ? excl_next : mask_q;
  end

  // Only the literal at idx_q moves; Type I clause=1/literal=0 and clause=0 share the decrement rule.
  always_comb begin
    for (int i = 0; i < NL; i++) begin
      logic inc, dec;
      inc      = 1'b0;
      dec      = 1'b0;
      cnt_d[i] = cnt_q[i];
      if (state_q == ST_UPDATE && idx_q == IDX_W'(i)) begin
        if (type_q == FB_TYPE1) begin
          if (clause_q && lits[i]) inc = !r_low;
          else                     dec = r_low;
        end else if (type_q == FB_TYPE2) begin
          inc = clause_q && !lits[i] && excl_now[i];
        end
      end
      if (inc && cnt_q[i] != CNT_MAX)      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec && cnt_q[i] != CNT_MIN) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      feat_q   <= '0;
      type_q   <= FB_NONE;
      clause_q <= 1'b0;
      mask_q   <= '1;
      for (int i = 0; i < NL; i++) cnt_q[i] <= CNT_MID;
    end else begin
      idx_q    <= idx_d;
      feat_q   <= feat_d;
      type_q   <= type_d;
      clause_q <= clause_d;
      mask_q   <= mask_d;
      for (int i = 0; i < NL; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign exclude_state = mask_q;
  assign clause_out    = clause_q;

endmodule
